serial_addsub_ctrl: RTL and testbench
=====================================

Name: serial_addsub_ctrl

Overview:
Bit-serial adder/subtractor sequencer built around a single one-bit full-adder/full-subtractor slice. The slice is NAND-only, the same gate style as the team's half/full adder and subtractor cells. The block latches two WIDTH-bit operands on a start handshake and steps the slice LSB-first, one bit per clock, holding carry/borrow in a flop. It reports the result through a busy/done handshake and gives upstream logic a small-area arithmetic unit in place of a parallel adder.

Parameters:
WIDTH, 8, operand/result width in bits (>= 2)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
mode  input  1  0 = add (a+b), 1 = subtract (a-b); sampled with start
a  input  WIDTH  operand A; sampled with start
b  input  WIDTH  operand B; sampled with start
busy  output  1  high while an operation is in LOAD/RUN
done  output  1  one-cycle pulse, result/cout valid
result  output  WIDTH  sum or difference, held until next accepted start
cout  output  1  add: carry out of MSB; sub: borrow out of MSB (1 iff a < b unsigned)

Behaviour:
- Reset: at a clk edge with rst=1, state=IDLE, busy=0, done=0, result=0, cout=0, carry flop=0, bit counter=0, shift regs=0. rst overrides every other input, including in the middle of RUN. The aborted operation produces no done.
- State IDLE: busy=0. start=1 at edge k: latch a, b, mode into shift regs, clear carry flop (add) or borrow flop (sub) to 0, counter=0, go to RUN. busy=1 from cycle k+1.
- State RUN: each edge feeds shift-reg LSBs plus the carry/borrow flop to the slice.
  - Add: s=x^y^c, c'=xy|c(x^y).
  - Sub: d=x^y^bw, bw'=(~x&y)|(~(x^y)&bw).
  - Shift the result bit in at the MSB of the result shift reg, shift both operands right, counter+1.
  - After the edge where counter reaches WIDTH-1, i.e. the WIDTH-th RUN edge (edge k+WIDTH), go to DONE.
- State DONE (one cycle, cycle k+WIDTH+1): done=1, busy=0, result = full WIDTH-bit value, cout = final carry/borrow. Next edge returns to IDLE unconditionally.
- Latency: start edge k to done high at cycle k+WIDTH+1. Throughput is one op per WIDTH+2 cycles.
- The result register is the shift register itself. result is only guaranteed correct while done=1 and afterwards until the next accepted start. During RUN it shows partial shifted data.
- start while busy=1 or in DONE: ignored, no queuing. Changes to a/b/mode after acceptance have no effect.
- Wrap-around: arithmetic is modulo 2^WIDTH. Overflow is signalled only via cout (and ovf when enabled).
- Simultaneous rst and start: reset wins; state stays IDLE.

Optional Feature:
Macro SERIAL_ADDSUB_OVF_EN.
- Defined: adds output ovf (1 bit) giving signed two's-complement overflow. Computed from the MSB step as carry-into-MSB XOR carry-out for add, and the same on the borrow chain for sub. ovf is valid with done and held like result; it resets to 0.
- Undefined: the ovf port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then start add a=100, b=27, WIDTH=8 -> done exactly 9 cycles after the start edge, result=127, cout=0, busy high for 8 cycles.
- Add a=200, b=100 -> result=44, cout=1; add a=255, b=1 -> result=0, cout=1.
- Sub a=9, b=5 -> result=4, cout=0; sub a=5, b=9 -> result=252, cout=1; sub a=b=170 -> result=0, cout=0.
- Start add 1+2, pulse start with a=50, b=50 on RUN cycle 3 -> only one done, result=3, and no second operation starts.
- Assert rst on RUN cycle 4 of add 15+15 -> next cycle busy=0, result=0, no done pulse. A new start for 7+8 then gives result=15.
- With SERIAL_ADDSUB_OVF_EN: add 127+1 -> result=128, ovf=1, cout=0. Sub 128-1 -> result=127, ovf=1. Add 3+4 -> ovf=0.

Source files
------------

// File: rtl/serial_addsub_ctrl.sv
// serial_addsub_ctrl: bit-serial add/subtract sequencer around one NAND-only
// full-adder/full-subtractor slice. Operands are shifted LSB-first, one bit
// per clock, with carry/borrow held in a flop between steps.
// Optional macro SERIAL_ADDSUB_OVF_EN adds a signed-overflow output (ovf).

// One-bit full adder / full subtractor built from two-input NANDs only.
// sub=0: s = x^y^ci, co = carry;  sub=1: s = x^y^ci, co = borrow.
module serial_addsub_slice (
    input  logic x,
    input  logic y,
    input  logic ci,
    input  logic sub,
    output logic s,
    output logic co
);
    logic n1, n2, n3, h, n5, n6, n7, cy;
    logic nx, hn, nb1, nb2, bw;
    logic nsub, t1, t2;

    // x ^ y
    assign n1 = ~(x & y);
    assign n2 = ~(x & n1);
    assign n3 = ~(y & n1);
    assign h  = ~(n2 & n3);
    // (x ^ y) ^ ci; sum and difference bits are identical
    assign n5 = ~(h & ci);
    assign n6 = ~(h & n5);
    assign n7 = ~(ci & n5);
    assign s  = ~(n6 & n7);
    // carry = xy | ci(x^y)
    assign cy = ~(n1 & n5);
    // borrow = (~x & y) | (~(x^y) & ci)
    assign nx  = ~(x & x);
    assign hn  = ~(h & h);
    assign nb1 = ~(nx & y);
    assign nb2 = ~(hn & ci);
    assign bw  = ~(nb1 & nb2);
    // select carry or borrow chain
    assign nsub = ~(sub & sub);
    assign t1   = ~(cy & nsub);
    assign t2   = ~(bw & sub);
    assign co   = ~(t1 & t2);
endmodule

module serial_addsub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] sa, sb;
    logic             md;
    logic             cflop;
    logic [CW-1:0]    cnt;
    logic             s_bit, c_nxt;

    serial_addsub_slice u_slice (
        .x   (sa[0]),
        .y   (sb[0]),
        .ci  (cflop),
        .sub (md),
        .s   (s_bit),
        .co  (c_nxt)
    );

    // Sequencer: load on start, shift one bit per clock, pulse done once.
    // result is the result shift register itself; it fills from the MSB end.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
            cflop  <= 1'b0;
            cnt    <= '0;
            sa     <= '0;
            sb     <= '0;
            md     <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        md    <= mode;
                        cflop <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    result <= {s_bit, result[WIDTH-1:1]};
                    sa     <= sa >> 1;
                    sb     <= sb >> 1;
                    cflop  <= c_nxt;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        cout  <= c_nxt;
`ifdef SERIAL_ADDSUB_OVF_EN
                        // carry/borrow into the MSB differs from the one out of it
                        ovf   <= cflop ^ c_nxt;
`endif
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Self-checking bench for serial_addsub_ctrl: directed cases plus random
// operations checked against an arithmetic reference model.
module tb_serial_addsub_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, start, mode;
    logic [W-1:0] a, b;
    logic         busy, done, cout;
    logic [W-1:0] result;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic         ovf;
`endif

    int n_cmp = 0;
    int n_err = 0;

    serial_addsub_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .mode   (mode),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout)
`ifdef SERIAL_ADDSUB_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: plain modular arithmetic on integers.
    task automatic model(input logic m, input int x, input int y,
                         output int r, output int c, output int v);
        int full, sx, sy, sr;
        full = m ? (x - y) : (x + y);
        r    = full & ((1 << W) - 1);
        c    = m ? int'(x < y) : int'(full >= (1 << W));
        sx   = (x >= (1 << (W-1))) ? x - (1 << W) : x;
        sy   = (y >= (1 << (W-1))) ? y - (1 << W) : y;
        sr   = m ? (sx - sy) : (sx + sy);
        v    = int'(sr >= (1 << (W-1)) || sr < -(1 << (W-1)));
    endtask

    // One operation. poke >= 0 re-asserts start (50,50) during that RUN cycle.
    task automatic do_op(input string tag, input logic m, input int x, input int y,
                         input int poke);
        int lat, bcnt, er, ec, ev, extra;
        model(m, x, y, er, ec, ev);
        @(negedge clk);
        a = W'(x); b = W'(y); mode = m; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); mode = 1'($urandom);
        lat = 0; bcnt = 0;
        while (!done && lat < 4*W) begin
            if (busy) bcnt++;
            if (lat == poke) begin
                start = 1'b1; a = W'(50); b = W'(50); mode = 1'b0;
            end else start = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        check({tag, ".done"}, 32'(done), 32'd1);
        check({tag, ".latency"}, lat, W);
        check({tag, ".busycycles"}, bcnt, W);
        check({tag, ".busy_at_done"}, 32'(busy), 32'd0);
        check({tag, ".result"}, 32'(result), er);
        check({tag, ".cout"}, 32'(cout), ec);
`ifdef SERIAL_ADDSUB_OVF_EN
        check({tag, ".ovf"}, 32'(ovf), ev);
`endif
        @(posedge clk); #1;
        check({tag, ".done_pulse"}, 32'(done), 32'd0);
        check({tag, ".result_held"}, 32'(result), er);
        if (poke >= 0) begin
            extra = 0;
            for (int i = 0; i < W + 3; i++) begin
                if (done || busy) extra++;
                @(posedge clk); #1;
            end
            check({tag, ".no_second_op"}, extra, 0);
        end
    endtask

    initial begin
        int lat, dcnt;
        rst = 1'b1; start = 1'b1; mode = 1'b0; a = 8'd3; b = 8'd4;
        repeat (2) @(posedge clk);
        #1;
        check("reset.busy", 32'(busy), 0);
        check("reset.done", 32'(done), 0);
        check("reset.result", 32'(result), 0);
        check("reset.cout", 32'(cout), 0);
`ifdef SERIAL_ADDSUB_OVF_EN
        check("reset.ovf", 32'(ovf), 0);
`endif
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        check("reset.stay_idle", 32'(busy), 0);

        do_op("add100_27", 1'b0, 100, 27, -1);
        do_op("add200_100", 1'b0, 200, 100, -1);
        do_op("add255_1", 1'b0, 255, 1, -1);
        do_op("sub9_5", 1'b1, 9, 5, -1);
        do_op("sub5_9", 1'b1, 5, 9, -1);
        do_op("sub170_170", 1'b1, 170, 170, -1);
        do_op("add1_2_poke", 1'b0, 1, 2, 2);
        do_op("add127_1", 1'b0, 127, 1, -1);
        do_op("sub128_1", 1'b1, 128, 1, -1);
        do_op("add3_4", 1'b0, 3, 4, -1);

        // Reset in the middle of RUN aborts with no done.
        @(negedge clk);
        a = 8'd15; b = 8'd15; mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort.busy", 32'(busy), 0);
        check("abort.result", 32'(result), 0);
        check("abort.done", 32'(done), 0);
        dcnt = 0;
        for (int i = 0; i < W + 3; i++) begin
            if (done || busy) dcnt++;
            @(posedge clk); #1;
        end
        check("abort.no_done", dcnt, 0);
        do_op("add7_8", 1'b0, 7, 8, -1);

        // Boundary operands then random ones.
        do_op("add0_0", 1'b0, 0, 0, -1);
        do_op("sub0_255", 1'b1, 0, 255, -1);
        for (int i = 0; i < 40; i++)
            do_op("rand", 1'($urandom), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 255)), -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
